// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types for the hazard control unit: register-ID width, FSM encoding
// and the shadow-pipeline slot that tracks in-flight register writers.
package hazard_ctrl_unit_pkg;

  localparam int NREG_W = 4;

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_DWAIT = 3'd1,
    ST_IWAIT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [NREG_W-1:0] dst;
    logic              regwrite;
    logic              memread;
    logic              hlt;
  } shadow_slot_t;

endpackage

// File: rtl/hazard_shadow_pipe.sv
// Three-slot shadow of the EX/MEM/WB pipeline registers. Advances in lockstep
// with EX/MEM; the caller decides whether the new EX entry is valid.
module hazard_shadow_pipe
  import hazard_ctrl_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_advance,
  input  shadow_slot_t i_ex_in,
  output shadow_slot_t o_ex,
  output shadow_slot_t o_mem,
  output shadow_slot_t o_wb
);

  shadow_slot_t r_ex;
  shadow_slot_t r_mem;
  shadow_slot_t r_wb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
    end else if (i_advance) begin
      r_ex  <= i_ex_in;
      r_mem <= r_ex;
      r_wb  <= r_mem;
    end
  end

  assign o_ex  = r_ex;
  assign o_mem = r_mem;
  assign o_wb  = r_wb;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: detects load-use and branch-register hazards
// against a shadow pipeline and drives all stage enables, bubbles and flushes.
module hazard_ctrl_unit
  import hazard_ctrl_unit_pkg::*;
#(
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREG_W-1:0] SrcReg1_ID,
  input  logic [NREG_W-1:0] SrcReg2_ID,
  input  logic              Src1Used_ID,
  input  logic              Src2Used_ID,
  input  logic              StoreIns_ID,
  input  logic [NREG_W-1:0] DstReg1_ID,
  input  logic              RegWrite_ID,
  input  logic              MemRead_ID,
  input  logic              BranchReg_ID,
  input  logic              BranchTaken_ID,
  input  logic              HLT_ID,
  input  logic              IMEM_stall,
  input  logic              DMEM_stall,
  output logic              PC_write,
  output logic              IFID_write,
  output logic              IFID_flush,
  output logic              IDEX_bubble,
  output logic              EXMEM_write,
  output logic              MEMWB_write,
  output logic              LoadUse_stall,
  output logic              Halted,
  output logic [PERF_W-1:0] StallCycles,
  output logic [2:0]        o_dbg_state
);

  state_e            r_state;
  state_e            w_next_state;
  logic              r_id_valid;
  logic [PERF_W-1:0] r_stall_cnt;

  shadow_slot_t w_ex_in, w_ex, w_mem, w_wb;
  logic w_hazard_ld, w_hazard_br, w_hazard;
  logic w_pc_write, w_ifid_write, w_ifid_flush, w_idex_bubble;
  logic w_exmem_write, w_memwb_write, w_loaduse, w_id_kill;
  logic w_unused;

  assign w_hazard_ld = w_ex.valid && w_ex.memread && w_ex.regwrite && (w_ex.dst != '0) &&
                       ((Src1Used_ID && (w_ex.dst == SrcReg1_ID)) ||
                        (Src2Used_ID && !StoreIns_ID && (w_ex.dst == SrcReg2_ID)));

  // Branch targets are read in ID with no forwarding path, so even an ALU
  // result in EX or a load in MEM must be waited out.
  assign w_hazard_br = BranchReg_ID && (SrcReg1_ID != '0) &&
                       ((w_ex.valid && w_ex.regwrite && (w_ex.dst == SrcReg1_ID)) ||
                        (w_mem.valid && w_mem.memread && (w_mem.dst == SrcReg1_ID)));

  assign w_hazard = w_hazard_ld || w_hazard_br;

  always_comb begin
    w_next_state  = r_state;
    w_pc_write    = 1'b1;
    w_ifid_write  = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;
    w_exmem_write = 1'b1;
    w_memwb_write = 1'b1;
    w_loaduse     = 1'b0;
    w_id_kill     = 1'b0;
    case (r_state)
      ST_HALT: begin
        w_pc_write    = 1'b0;
        w_ifid_write  = 1'b0;
        w_exmem_write = 1'b0;
        w_memwb_write = 1'b0;
      end
      ST_DRAIN: begin
        w_pc_write   = 1'b0;
        w_ifid_write = 1'b0;
        if (DMEM_stall) begin
          w_exmem_write = 1'b0;
          w_memwb_write = 1'b0;
        end else begin
          w_idex_bubble = 1'b1;
          // HLT is leaving MEM this edge, so WB holds it next cycle.
          if (w_mem.valid && w_mem.hlt) w_next_state = ST_HALT;
        end
      end
      default: begin
        // DMEM_stall acts in the same cycle it rises and falls; the
        // registered state only records which wait is in progress.
        if (DMEM_stall) begin
          w_next_state  = ST_DWAIT;
          w_pc_write    = 1'b0;
          w_ifid_write  = 1'b0;
          w_exmem_write = 1'b0;
          w_memwb_write = 1'b0;
        end else if (IMEM_stall) begin
          w_next_state = ST_IWAIT;
          w_pc_write   = 1'b0;
          w_ifid_write = 1'b0;
          if (!r_id_valid || w_hazard) w_idex_bubble = 1'b1;
          else                         w_id_kill     = 1'b1;
        end else if (w_hazard) begin
          w_next_state  = ST_RUN;
          w_pc_write    = 1'b0;
          w_ifid_write  = 1'b0;
          w_idex_bubble = 1'b1;
          w_loaduse     = w_hazard_ld;
        end else if (HLT_ID) begin
          w_next_state = ST_DRAIN;
          w_pc_write   = 1'b0;
          w_ifid_write = 1'b0;
          w_id_kill    = 1'b1;
        end else begin
          w_next_state = ST_RUN;
          w_ifid_flush = BranchTaken_ID;
        end
      end
    endcase
  end

  assign w_ex_in.valid    = r_id_valid && !w_idex_bubble;
  assign w_ex_in.dst      = DstReg1_ID;
  assign w_ex_in.regwrite = RegWrite_ID;
  assign w_ex_in.memread  = MemRead_ID;
  assign w_ex_in.hlt      = HLT_ID;

  hazard_shadow_pipe u_shadow (
    .clk       (clk),
    .rst       (rst),
    .i_advance (w_exmem_write),
    .i_ex_in   (w_ex_in),
    .o_ex      (w_ex),
    .o_mem     (w_mem),
    .o_wb      (w_wb)
  );

  assign w_unused = ^{w_wb, w_mem.regwrite};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_id_valid  <= 1'b1;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      // IF/ID goes empty when flushed or when ID moved on with no refetch.
      if (w_ifid_flush || w_id_kill) r_id_valid <= 1'b0;
      else if (w_ifid_write)         r_id_valid <= 1'b1;
      if (!w_pc_write && (r_state != ST_HALT) && (r_stall_cnt != {PERF_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign PC_write      = w_pc_write;
  assign IFID_write    = w_ifid_write;
  assign IFID_flush    = w_ifid_flush;
  assign IDEX_bubble   = w_idex_bubble;
  assign EXMEM_write   = w_exmem_write;
  assign MEMWB_write   = w_memwb_write;
  assign LoadUse_stall = w_loaduse;
  assign Halted        = (r_state == ST_HALT);
  assign StallCycles   = r_stall_cnt;
  assign o_dbg_state   = r_state;

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Producer-side counterpart to the EX/MEM forwarding logic. It tracks in-flight register writers in a shadow EX/MEM/WB pipeline and decides when a consumer in ID cannot be served by forwarding.
- Generates all pipeline write-enables, bubbles and flushes: load-use stall, branch-register stall, taken-branch flush, I/D memory wait freezes, halt drain.
- Sits beside the ID stage and drives PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.

Parameters:
- NREG_W, 4, register-ID width (R0 hardwired zero, never a hazard)
- PERF_W, 16, width of saturating stall-cycle counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- SrcReg1_ID  in  NREG_W  ID-stage source 1
- SrcReg2_ID  in  NREG_W  ID-stage source 2
- Src1Used_ID, Src2Used_ID  in  1  source actually read
- StoreIns_ID  in  1  ID instr is SW; src2 is store data and is mem2mem-forwardable
- DstReg1_ID  in  NREG_W  ID destination
- RegWrite_ID, MemRead_ID  in  1  ID instr writes reg / is load
- BranchReg_ID  in  1  BR in ID reads SrcReg1_ID for target (no forwarding into ID)
- BranchTaken_ID  in  1  branch resolved taken in ID
- HLT_ID  in  1  HLT opcode in ID
- IMEM_stall, DMEM_stall  in  1  cache miss pending
- PC_write, IFID_write, IFID_flush, IDEX_bubble, EXMEM_write, MEMWB_write  out  1
- LoadUse_stall  out  1  diagnostic
- Halted  out  1  sticky halt
- StallCycles  out  PERF_W  saturating count of cycles with PC_write=0 and ~Halted

Behaviour:
- Reset (async): shadow slots invalid, FSM=RUN, Halted=0, StallCycles=0. All write enables=1; IFID_flush=0; IDEX_bubble=0.
- Shadow slots EX/MEM/WB each hold {valid, dst, regwrite, memread, hlt}. Advance when EXMEM_write=1. The EX slot loads the ID fields, or becomes invalid when IDEX_bubble=1 or the ID instruction is flushed.
- hazard_ld = EX.valid & EX.memread & EX.regwrite & EX.dst!=0 & ((Src1Used_ID & EX.dst==SrcReg1_ID) | (Src2Used_ID & ~StoreIns_ID & EX.dst==SrcReg2_ID)).
- hazard_br = BranchReg_ID & SrcReg1_ID!=0 & ((EX.valid & EX.regwrite & EX.dst==SrcReg1_ID) | (MEM.valid & MEM.memread & MEM.dst==SrcReg1_ID)).
- FSM states: RUN, DWAIT, IWAIT, DRAIN, HALT. Priority when simultaneous: DMEM_stall > IMEM_stall > hazard_ld/hazard_br > BranchTaken_ID.
  - DWAIT (DMEM_stall=1): every write enable=0, no bubble, shadow frozen. Exit to RUN the cycle after DMEM_stall drops.
  - IWAIT (IMEM_stall=1, no DMEM_stall): PC_write=IFID_write=0; IDEX_bubble=1 only if ID holds no valid instruction, otherwise ID advances normally and IF/ID marked flushed; back ends run.
  - RUN hazard: PC_write=IFID_write=0, IDEX_bubble=1, LoadUse_stall=hazard_ld. Combinational, same cycle. Lasts exactly one cycle for a load-use; up to two for a branch on a load.
  - BranchTaken_ID, no stall: IFID_flush=1 for one cycle. Ignored while any stall is asserted; the branch re-evaluates when unstalled.
  - HLT_ID, no stall: go to DRAIN, PC_write=0 thereafter, and ID/EX bubbles after HLT passes. HALT entered when the WB slot has hlt=1. In HALT, Halted=1 and all write enables=0 until rst.
- Reset mid-stall or mid-drain returns to RUN with empty shadow; no residual bubbles.
- StallCycles saturates at all-ones; never wraps.

Decomposition:
- Shared package: NREG_W, FSM state encoding, shadow-slot struct {valid,dst,regwrite,memread,hlt}.
- One sub-module: hazard_shadow_pipe (three-slot shadow register with advance/bubble/flush). Comparators and FSM stay in the top.

Test Plan:
- LW R3 then ADD R4,R3,R5 -> one cycle LoadUse_stall=1, PC_write=0, IDEX_bubble=1; next cycle all enables=1.
- LW R3 then SW R3 (store data) -> no stall; LW R3 then SW R6,R3 as base (Src1) -> one stall cycle.
- ADD R2 then BR R2 -> one stall; LW R2 then BR R2 -> two stall cycles, then IFID_flush=1 if taken.
- DMEM_stall high 5 cycles coincident with a load-use hazard -> 5 cycles all enables=0, then one load-use bubble; StallCycles=6.
- BranchTaken_ID with IMEM_stall=1 -> no flush until IMEM_stall drops, then IFID_flush=1 for exactly one cycle.
- HLT in ID with prior writers in flight -> PC_write=0 immediately; Halted=1 exactly 3 cycles later; assert rst mid-drain -> Halted=0, enables=1.
